// File: rtl/xc_malu_divrem_iter.sv
// xc_malu_divrem_iter: iterative restoring divider/remainder, STEP quotient bits per cycle,
// with RISC-V divide-by-zero and signed-overflow results produced by the datapath itself.
module xc_malu_divrem_iter #(
    parameter int XLEN = 32,
    parameter int STEP = 1,
    parameter int CW   = $clog2(XLEN / STEP) + 1
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            valid,
    input  logic            op_signed,
    input  logic            flush,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);
    localparam int N = XLEN / STEP;

    generate
        if ((STEP != 1 && STEP != 2 && STEP != 4) || (XLEN % STEP) != 0 || XLEN < 8 || (XLEN % 2) != 0) begin : g_bad_params
            $error("xc_malu_divrem_iter: illegal XLEN/STEP combination");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] part, dvd, dvs, part_n, dvd_n, abs1, abs2;
    logic [XLEN+1:0] trial;
    logic            neg_q, neg_r, accept, last;

    // Magnitudes wrap in XLEN bits, so the most negative value maps to itself.
    assign abs1   = (op_signed && rs1[XLEN-1]) ? -rs1 : rs1;
    assign abs2   = (op_signed && rs2[XLEN-1]) ? -rs2 : rs2;
    assign last   = cnt == CW'(N - 1);
    assign accept = state == IDLE && state_n == RUN;

    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = valid ? RUN : IDLE;
            RUN:  state_n = !valid ? IDLE : (last ? FIX : RUN);
            FIX:  state_n = valid ? DONE : IDLE;
            DONE: state_n = valid ? DONE : IDLE;
        endcase
        if (flush)
            state_n = IDLE;
    end

    // Dividend bits shift out of dvd's MSB while quotient bits shift into its LSB.
    always_comb begin
        part_n = part;
        dvd_n  = dvd;
        trial  = '0;
        for (int i = 0; i < STEP; i++) begin
            trial  = {1'b0, part_n, dvd_n[XLEN-1]} - {2'b00, dvs};
            part_n = trial[XLEN+1] ? {part_n[XLEN-2:0], dvd_n[XLEN-1]} : trial[XLEN-1:0];
            dvd_n  = {dvd_n[XLEN-2:0], ~trial[XLEN+1]};
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            cnt       <= '0;
            part      <= '0;
            dvd       <= '0;
            dvs       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
        end else begin
            state <= state_n;
            busy  <= state_n == RUN || state_n == FIX;
            done  <= state_n == DONE;
            if (accept) begin
                part  <= '0;
                dvd   <= abs1;
                dvs   <= abs2;
                neg_q <= op_signed && (rs1[XLEN-1] != rs2[XLEN-1]) && (|rs2);
                neg_r <= op_signed && rs1[XLEN-1];
                cnt   <= '0;
            end else if (state == RUN) begin
                part <= part_n;
                dvd  <= dvd_n;
                cnt  <= cnt + CW'(1);
            end
            if (state == FIX && state_n == DONE) begin
                quotient  <= neg_q ? -dvd : dvd;
                remainder <= neg_r ? -part : part;
            end
        end
    end
endmodule
